// File: rtl/bkg_scroll_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : bkg_scroll_ctrl_if
// Description : Frame-update bus between timing/controller side and the
//               background scroll controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface bkg_scroll_ctrl_if;
    logic        screenEnd;
    logic [7:0]  buttons;
    logic        bkg_en;
    logic [31:0] bkg_addr;
    logic [7:0]  bkg_x;
    logic [6:0]  bkg_y;
    logic        update_done;
    logic        busy;

    // Timing generator / controller side
    modport master (
        output screenEnd,
        output buttons,
        input  bkg_en,
        input  bkg_addr,
        input  bkg_x,
        input  bkg_y,
        input  update_done,
        input  busy
    );

    // Scroll controller side
    modport slave (
        input  screenEnd,
        input  buttons,
        output bkg_en,
        output bkg_addr,
        output bkg_x,
        output bkg_y,
        output update_done,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/bkg_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bkg_scroll_ctrl
// Description : Once-per-frame cursor move and vertical background scroll,
//               committing all display offsets atomically.
// Revision    : 1.0 - initial release
// ============================================================================
module bkg_scroll_ctrl #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int PAGES    = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    bkg_scroll_ctrl_if.slave  bus
);

    localparam logic [7:0] c_X_MAX      = 8'(SCREEN_W - 1);
    localparam logic [6:0] c_Y_MAX      = 7'(SCREEN_H - 1);
    localparam logic [7:0] c_MAX_SCROLL = 8'((PAGES - 1) * SCREEN_H);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SAMPLE = 2'd1,
        S_MOVE   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [7:0]  r_btn_meta;
    logic [7:0]  r_btn_s;
    logic [7:0]  r_btn_l;
    logic        r_start_prev;

    logic [7:0]  r_cur_x;
    logic [6:0]  r_cur_y;
    logic [7:0]  r_scroll_row;
    logic        r_en_w;

    logic        r_bkg_en;
    logic [31:0] r_bkg_addr;
    logic [7:0]  r_bkg_x;
    logic [6:0]  r_bkg_y;
    logic        r_update_done;

    logic [7:0]  w_cur_x_nxt;
    logic [6:0]  w_cur_y_nxt;
    logic [7:0]  w_row_nxt;
    logic        w_en_nxt;
    logic        w_start_rise;
    logic        w_left;
    logic        w_right;
    logic        w_up;
    logic        w_down;
    logic [31:0] w_addr;
    logic        w_unused_ab;

    // A and B buttons have no function in this block
    assign w_unused_ab = ^r_btn_l[5:4];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.screenEnd) w_state_next = S_SAMPLE;
            S_SAMPLE: w_state_next = S_MOVE;
            S_MOVE:   w_state_next = S_COMMIT;
            S_COMMIT: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Move rules, evaluated from the latched buttons
    // ------------------------------------------------------------------
    always_comb begin
        w_start_rise = r_btn_l[6] & ~r_start_prev;
        w_left       = r_btn_l[2] & ~r_btn_l[3];
        w_right      = r_btn_l[3] & ~r_btn_l[2];
        w_up         = r_btn_l[0] & ~r_btn_l[1];
        w_down       = r_btn_l[1] & ~r_btn_l[0];
        w_cur_x_nxt  = r_cur_x;
        w_cur_y_nxt  = r_cur_y;
        w_row_nxt    = r_scroll_row;
        w_en_nxt     = r_en_w ^ w_start_rise;

        if (r_btn_l[7]) begin
            w_cur_x_nxt = 8'd0;
            w_cur_y_nxt = 7'd0;
            w_row_nxt   = 8'd0;
        end else begin
            if (w_left && (r_cur_x != 8'd0)) begin
                w_cur_x_nxt = r_cur_x - 8'd1;
            end else if (w_right && (r_cur_x < c_X_MAX)) begin
                w_cur_x_nxt = r_cur_x + 8'd1;
            end

            // Cursor moves first; the window scrolls only once the cursor is pinned at an edge
            if (w_up) begin
                if (r_cur_y != 7'd0) begin
                    w_cur_y_nxt = r_cur_y - 7'd1;
                end else if (r_scroll_row != 8'd0) begin
                    w_row_nxt = r_scroll_row - 8'd1;
                end
            end else if (w_down) begin
                if (r_cur_y < c_Y_MAX) begin
                    w_cur_y_nxt = r_cur_y + 7'd1;
                end else if (r_scroll_row < c_MAX_SCROLL) begin
                    w_row_nxt = r_scroll_row + 8'd1;
                end
            end
        end
    end

    generate
        if (SCREEN_W == 160) begin : g_addr_shift
            assign w_addr = ({24'd0, r_scroll_row} << 7) + ({24'd0, r_scroll_row} << 5);
        end else begin : g_addr_mul
            assign w_addr = 32'(r_scroll_row) * 32'(SCREEN_W);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Synchronizer, working registers and committed outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_meta    <= 8'd0;
            r_btn_s       <= 8'd0;
            r_btn_l       <= 8'd0;
            r_start_prev  <= 1'b0;
            r_cur_x       <= 8'd0;
            r_cur_y       <= 7'd0;
            r_scroll_row  <= 8'd0;
            r_en_w        <= 1'b1;
            r_bkg_en      <= 1'b1;
            r_bkg_addr    <= 32'd0;
            r_bkg_x       <= 8'd0;
            r_bkg_y       <= 7'd0;
            r_update_done <= 1'b0;
        end else begin
            r_btn_meta    <= bus.buttons;
            r_btn_s       <= r_btn_meta;
            r_update_done <= 1'b0;
            case (r_state)
                S_SAMPLE: begin
                    r_btn_l <= r_btn_s;
                end
                S_MOVE: begin
                    r_start_prev <= r_btn_l[6];
                    r_cur_x      <= w_cur_x_nxt;
                    r_cur_y      <= w_cur_y_nxt;
                    r_scroll_row <= w_row_nxt;
                    r_en_w       <= w_en_nxt;
                end
                S_COMMIT: begin
                    r_bkg_addr    <= w_addr;
                    r_bkg_x       <= r_cur_x;
                    r_bkg_y       <= r_cur_y;
                    r_bkg_en      <= r_en_w;
                    r_update_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.bkg_en      = r_bkg_en;
    assign bus.bkg_addr    = r_bkg_addr;
    assign bus.bkg_x       = r_bkg_x;
    assign bus.bkg_y       = r_bkg_y;
    assign bus.update_done = r_update_done;
    assign bus.busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bkg_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bkg_scroll_ctrl
// Description : Randomized and directed self-checking bench for bkg_scroll_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bkg_scroll_ctrl;

    logic clk;
    logic reset;

    bkg_scroll_ctrl_if u_if ();

    bkg_scroll_ctrl #(
        .SCREEN_W (160),
        .SCREEN_H (120),
        .PAGES    (2)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_x;
    int m_y;
    int m_row;
    bit m_en;
    bit m_start_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x          = 0;
        m_y          = 0;
        m_row        = 0;
        m_en         = 1'b1;
        m_start_prev = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] b);
        bit rise;
        rise         = b[6] && !m_start_prev;
        m_start_prev = b[6];
        if (b[7]) begin
            m_x = 0; m_y = 0; m_row = 0;
        end else begin
            if (b[2] && !b[3])      m_x = (m_x > 0)   ? m_x - 1 : 0;
            else if (b[3] && !b[2]) m_x = (m_x < 159) ? m_x + 1 : 159;
            if (b[0] && !b[1]) begin
                if (m_y > 0)        m_y--;
                else if (m_row > 0) m_row--;
            end else if (b[1] && !b[0]) begin
                if (m_y < 119)        m_y++;
                else if (m_row < 120) m_row++;
            end
        end
        if (rise) m_en = !m_en;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".en"},   32'(u_if.bkg_en), 32'(m_en));
        check({tag, ".addr"}, u_if.bkg_addr,    32'(m_row * 160));
        check({tag, ".x"},    32'(u_if.bkg_x),  32'(m_x));
        check({tag, ".y"},    32'(u_if.bkg_y),  32'(m_y));
    endtask

    // Count update_done pulses over a window; none expected after a commit
    task automatic check_quiet(input string tag, input int cycles);
        int cnt;
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (u_if.update_done) cnt++;
        end
        check(tag, 32'(cnt), 32'd0);
        check({tag, ".busy"}, 32'(u_if.busy), 32'd0);
    endtask

    task automatic run_frame(input logic [7:0] b, input bit extra_pulse);
        int lat;
        bit done;
        @(negedge clk);
        u_if.buttons = b;
        repeat (3) @(negedge clk);
        check_outputs("hold");
        u_if.screenEnd = 1'b1;
        @(posedge clk); #1;
        u_if.screenEnd = 1'b0;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 2) u_if.screenEnd = 1'b0;
            if (lat == 1) check("busy", 32'(u_if.busy), 32'd1);
            if (u_if.update_done) done = 1'b1;
            if (extra_pulse && lat == 1) u_if.screenEnd = 1'b1;
        end
        u_if.screenEnd = 1'b0;
        check("latency", 32'(lat), 32'd3);
        model_frame(b);
        check_outputs("frame");
        check_quiet("extra_upd", 6);
    endtask

    task automatic reset_abort(input logic [7:0] b);
        @(negedge clk);
        u_if.buttons = b;
        repeat (3) @(negedge clk);
        u_if.screenEnd = 1'b1;
        @(posedge clk); #1;            // entered SAMPLE
        u_if.screenEnd = 1'b0;
        @(posedge clk); #1;            // entered MOVE
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        check_outputs("abort");
        check("abort.busy", 32'(u_if.busy), 32'd0);
        check("abort.upd", 32'(u_if.update_done), 32'd0);
        check_quiet("abort_quiet", 6);
    endtask

    initial begin
        logic [7:0] b;
        reset          = 1'b1;
        u_if.screenEnd = 1'b0;
        u_if.buttons   = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_outputs("reset");
        check("reset.busy", 32'(u_if.busy), 32'd0);
        check("reset.upd",  32'(u_if.update_done), 32'd0);

        repeat (3)   run_frame(8'h00, 1'b0);
        repeat (200) run_frame(8'h08, 1'b0);   // right, saturates at 159
        repeat (119) run_frame(8'h02, 1'b0);   // down to bottom row
        repeat (125) run_frame(8'h02, 1'b0);   // scroll to max
        run_frame(8'h01, 1'b0);                // up moves cursor only

        repeat (5) run_frame(8'h40, 1'b0);     // start held: one toggle
        run_frame(8'h00, 1'b0);
        run_frame(8'h40, 1'b0);
        repeat (2) run_frame(8'h03, 1'b0);     // up+down
        repeat (2) run_frame(8'h0C, 1'b0);     // left+right
        run_frame(8'h30, 1'b0);                // A+B ignored

        run_frame(8'h80, 1'b0);
        repeat (50)  run_frame(8'h08, 1'b0);
        repeat (124) run_frame(8'h02, 1'b0);   // y=119, row=5 -> addr 800
        check("pre_sel.addr", u_if.bkg_addr, 32'd800);
        run_frame(8'h8A, 1'b1);                // select wins, extra screenEnd ignored

        repeat (20) run_frame(8'h0A, 1'b0);
        reset_abort(8'h08);
        run_frame(8'h08, 1'b0);

        for (int i = 0; i < 200; i++) begin
            b = 8'($urandom);
            if (b[7] && ($urandom_range(0, 7) != 0)) b[7] = 1'b0;
            run_frame(b, ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bkg_scroll_ctrl.md
Name: bkg_scroll_ctrl

Overview:
- Frame-rate controller directly upstream of the VGA game display stage; drives its bkg_en, bkg_addr, bkg_x and bkg_y inputs.
- Once per frame, on the screenEnd pulse, samples the controller buttons. It then moves a cursor, vertically scrolls the background window through a multi-page graphics memory, and commits all outputs atomically.
- Outputs are held stable for the whole active frame, so the display never sees a half-updated offset.

Parameters:
- SCREEN_W, 160, visible background width in memory pixels (one address per pixel)
- SCREEN_H, 120, visible background height in memory pixels
- PAGES, 2, number of screen-heights stored in graphics memory
- MAX_SCROLL, (PAGES-1)*SCREEN_H, largest legal scroll row (derived; not overridden)

Ports:
- clk  input  1  system clock; the only clock
- reset  input  1  synchronous, active-high reset
- screenEnd  input  1  one-cycle pulse from the timing generator between frames
- buttons  input  8  raw controller buttons, asynchronous. Bit map: 0 up, 1 down, 2 left, 3 right, 4 A, 5 B, 6 start, 7 select
- bkg_en  output  1  background offset enable
- bkg_addr  output  32  scroll_row*SCREEN_W, the linear memory offset of the top visible row
- bkg_x  output  8  cursor x, range 0..SCREEN_W-1
- bkg_y  output  7  cursor y, range 0..SCREEN_H-1
- update_done  output  1  one-cycle pulse when new outputs are committed
- busy  output  1  high while the FSM is not IDLE

Behaviour:
- Clock and reset: all registers use posedge clk. Reset is synchronous and active-high.
- Reset values: bkg_en=1, bkg_addr=0, bkg_x=0, bkg_y=0, update_done=0, busy=0, scroll_row=0, state=IDLE, synchronizers=0, start_prev=0.
- Reset asserted mid-update aborts the update. No partial commit is allowed.
- Input synchronization: buttons pass through a 2-flop synchronizer (btn_s). FSM decisions use only btn_s.
- FSM states: IDLE, SAMPLE, MOVE, COMMIT.
  - IDLE -> SAMPLE when screenEnd=1.
  - SAMPLE: latch btn_s into btn_l. Compute start_rise = btn_l[6] & ~start_prev, then set start_prev <= btn_l[6]. Go to MOVE.
  - MOVE: update the working registers cur_x, cur_y, scroll_row and en_w using the rules below. Go to COMMIT.
  - COMMIT: bkg_addr <= scroll_row*SCREEN_W, implemented as (scroll_row<<7)+(scroll_row<<5) for the default width; generic multiply is allowed. Also bkg_x<=cur_x, bkg_y<=cur_y, bkg_en<=en_w, update_done<=1. Go to IDLE.
- Latency: screenEnd sampled high at edge N gives outputs and update_done valid after edge N+3. update_done is high for exactly one cycle.
- busy is high in SAMPLE, MOVE and COMMIT. A screenEnd arriving while busy is ignored; it is not queued.
- Move rules (MOVE state), applied in priority order:
  1. select (bit 7) high: cur_x=0, cur_y=0, scroll_row=0. Movement is ignored this frame. en_w is still toggled if start_rise is set.
  2. Horizontal: left only gives cur_x-1, saturating at 0. Right only gives cur_x+1, saturating at SCREEN_W-1. Left and right together give no change.
  3. Vertical: up and down together give no change.
     - Up only: if cur_y>0, cur_y-1. Else if scroll_row>0, scroll_row-1. Else no change.
     - Down only: if cur_y<SCREEN_H-1, cur_y+1. Else if scroll_row<MAX_SCROLL, scroll_row+1. Else no change.
  4. start_rise: en_w = ~en_w. Holding start toggles only once.
- Horizontal and vertical moves in the same frame both apply (diagonal motion).
- A and B (bits 4 and 5) are ignored by this block.
- Movement is level-sensitive: at most one step per frame per axis.
- Width rules:
  - scroll_row is 8 bits (MAX_SCROLL=120).
  - bkg_addr is zero-extended to 32 bits; maximum value 120*160=19200.
  - cur_x and cur_y never leave their ranges.
- Between updates, every output holds its value regardless of buttons.

Test Plan:
- Reset, then hold no buttons for 3 frames -> bkg_en=1, bkg_addr=0, bkg_x=0, bkg_y=0; update_done pulses once per frame, exactly 3 cycles after each screenEnd.
- Hold right for 200 frames -> bkg_x counts 1,2,... and saturates at 159. bkg_y=0 and bkg_addr=0 throughout.
- Hold down for 119 frames -> bkg_y=119, bkg_addr=0. After 3 more frames: bkg_addr=160, 320, 480. After 120+ total extra frames: bkg_addr saturates at 19200. Then press up once -> bkg_y=118, bkg_addr unchanged.
- Hold start for 5 frames, release, then hold it for 1 frame -> bkg_en goes 1->0 after the first frame, stays 0, then returns to 1. Up+down and left+right held together -> no position change.
- From bkg_x=50, bkg_y=119, bkg_addr=800, hold select+right+down -> next commit gives x=0, y=0, addr=0. A second screenEnd during busy -> no extra update_done.
- Assert reset in the cycle after SAMPLE -> all outputs return to reset values, no update_done pulse, and the next screenEnd updates normally.
